// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, memory-stall hold and flush squash.
// Optional stall counter output enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_hazard_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_ra,
  input  logic [2:0]  id_rb,
  input  logic [2:0]  id_use,
  input  logic        id_rf_we,
  input  logic [2:0]  id_rf_waddr,
  input  logic        id_is_load,
  input  logic [35:0] id_payload,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ex_ra,
  output logic [2:0]  ex_rb,
  output logic [2:0]  ex_use,
  output logic        ex_rf_we,
  output logic [2:0]  ex_rf_waddr,
  output logic        ex_is_load,
  output logic [35:0] ex_payload,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        stall_if_id
);

  logic        ex_valid_reg,    ex_valid_next;
  logic [2:0]  ex_ra_reg,       ex_ra_next;
  logic [2:0]  ex_rb_reg,       ex_rb_next;
  logic [2:0]  ex_use_reg,      ex_use_next;
  logic        ex_rf_we_reg,    ex_rf_we_next;
  logic [2:0]  ex_rf_waddr_reg, ex_rf_waddr_next;
  logic        ex_is_load_reg,  ex_is_load_next;
  logic [35:0] ex_payload_reg,  ex_payload_next;
  logic        lu;
  logic        hit_a;
  logic        hit_b;

  // Store data travels on ra, so a store read counts as an ra read.
  assign hit_a = (id_use[0] | id_use[2]) & (id_ra == ex_rf_waddr_reg);
  assign hit_b = id_use[1] & (id_rb == ex_rf_waddr_reg);
  assign lu    = ex_valid_reg & ex_is_load_reg & ex_rf_we_reg &
                 (ex_rf_waddr_reg != 3'd0) & id_valid & (hit_a | hit_b);

  assign stall_if_id = ~flush & (mem_stall | lu);

  always_comb begin
    ex_valid_next    = ex_valid_reg;
    ex_ra_next       = ex_ra_reg;
    ex_rb_next       = ex_rb_reg;
    ex_use_next      = ex_use_reg;
    ex_rf_we_next    = ex_rf_we_reg;
    ex_rf_waddr_next = ex_rf_waddr_reg;
    ex_is_load_next  = ex_is_load_reg;
    ex_payload_next  = ex_payload_reg;
    if (flush || (!mem_stall && lu)) begin
      ex_valid_next    = 1'b0;
      ex_ra_next       = 3'd0;
      ex_rb_next       = 3'd0;
      ex_use_next      = 3'd0;
      ex_rf_we_next    = 1'b0;
      ex_rf_waddr_next = 3'd0;
      ex_is_load_next  = 1'b0;
      ex_payload_next  = 36'd0;
    end else if (!mem_stall) begin
      ex_valid_next    = id_valid;
      ex_ra_next       = id_ra;
      ex_rb_next       = id_rb;
      ex_use_next      = id_valid ? id_use : 3'd0;
      ex_rf_we_next    = id_valid & id_rf_we;
      ex_rf_waddr_next = id_rf_waddr;
      ex_is_load_next  = id_valid & id_is_load;
      ex_payload_next  = id_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg    <= 1'b0;
      ex_ra_reg       <= 3'd0;
      ex_rb_reg       <= 3'd0;
      ex_use_reg      <= 3'd0;
      ex_rf_we_reg    <= 1'b0;
      ex_rf_waddr_reg <= 3'd0;
      ex_is_load_reg  <= 1'b0;
      ex_payload_reg  <= 36'd0;
    end else begin
      ex_valid_reg    <= ex_valid_next;
      ex_ra_reg       <= ex_ra_next;
      ex_rb_reg       <= ex_rb_next;
      ex_use_reg      <= ex_use_next;
      ex_rf_we_reg    <= ex_rf_we_next;
      ex_rf_waddr_reg <= ex_rf_waddr_next;
      ex_is_load_reg  <= ex_is_load_next;
      ex_payload_reg  <= ex_payload_next;
    end
  end

  assign ex_valid    = ex_valid_reg;
  assign ex_ra       = ex_ra_reg;
  assign ex_rb       = ex_rb_reg;
  assign ex_use      = ex_use_reg;
  assign ex_rf_we    = ex_rf_we_reg;
  assign ex_rf_waddr = ex_rf_waddr_reg;
  assign ex_is_load  = ex_is_load_reg;
  assign ex_payload  = ex_payload_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Counts only bubbles actually inserted for load-use, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 16'd0;
    end else if (lu && !flush && !mem_stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed self-checking bench for id_ex_hazard_reg; covers HAZARD_PERF_CNT_EN when defined.
module tb_id_ex_hazard_reg;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_ra;
  logic [2:0]  id_rb;
  logic [2:0]  id_use;
  logic        id_rf_we;
  logic [2:0]  id_rf_waddr;
  logic        id_is_load;
  logic [35:0] id_payload;
  logic        mem_stall;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_ra;
  logic [2:0]  ex_rb;
  logic [2:0]  ex_use;
  logic        ex_rf_we;
  logic [2:0]  ex_rf_waddr;
  logic        ex_is_load;
  logic [35:0] ex_payload;
  logic        stall_if_id;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  id_ex_hazard_reg dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb), .id_use(id_use),
    .id_rf_we(id_rf_we), .id_rf_waddr(id_rf_waddr), .id_is_load(id_is_load),
    .id_payload(id_payload), .mem_stall(mem_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_use(ex_use),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_is_load(ex_is_load),
    .ex_payload(ex_payload),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall_if_id(stall_if_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [2:0] use_f, input logic we, input logic [2:0] wa,
                        input logic ld, input logic [35:0] pl);
    id_valid = v; id_ra = ra; id_rb = rb; id_use = use_f;
    id_rf_we = we; id_rf_waddr = wa; id_is_load = ld; id_payload = pl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 36'd0);
    #1;
    vectors++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
    vectors++;
    if (ex_payload !== 36'd0) begin errors++; $display("FAIL reset_payload: got %0h want 0", ex_payload); end
    vectors++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", stall_if_id); end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", stall_cnt); end
`endif
    step; step;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_advance;
    set_id(1, 3'd1, 3'd2, 3'b011, 1, 3'd5, 0, 36'h912345678);
    step;
    vectors++;
    if (ex_valid !== 1'b1 || ex_ra !== 3'd1 || ex_rb !== 3'd2 || ex_use !== 3'b011)
      begin errors++; $display("FAIL adv_regs: got v=%0h ra=%0h rb=%0h use=%0h want v=1 ra=1 rb=2 use=3",
                               ex_valid, ex_ra, ex_rb, ex_use); end
    vectors++;
    if (ex_rf_we !== 1'b1 || ex_rf_waddr !== 3'd5 || ex_is_load !== 1'b0 || ex_payload !== 36'h912345678)
      begin errors++; $display("FAIL adv_ctrl: got we=%0h wa=%0h ld=%0h pl=%0h want we=1 wa=5 ld=0 pl=912345678",
                               ex_rf_we, ex_rf_waddr, ex_is_load, ex_payload); end
    set_id(0, 3'd6, 3'd7, 3'b111, 1, 3'd6, 1, 36'h1);
    step;
    vectors++;
    if (ex_valid !== 1'b0 || ex_use !== 3'b000 || ex_rf_we !== 1'b0 || ex_is_load !== 1'b0)
      begin errors++; $display("FAIL adv_invalid_gate: got v=%0h use=%0h we=%0h ld=%0h want all 0",
                               ex_valid, ex_use, ex_rf_we, ex_is_load); end
    $display("test_advance done");
  endtask

  task automatic test_load_use;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd3, 1, 36'hA00000001);
    step;
    set_id(1, 3'd3, 3'd2, 3'b011, 1, 3'd4, 0, 36'hB00000002);
    #1;
    vectors++;
    if (stall_if_id !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0h want 1", stall_if_id); end
    step;
    vectors++;
    if (ex_valid !== 1'b0 || ex_payload !== 36'd0 || ex_ra !== 3'd0 || ex_rf_waddr !== 3'd0)
      begin errors++; $display("FAIL lu_bubble: got v=%0h pl=%0h ra=%0h wa=%0h want all 0",
                               ex_valid, ex_payload, ex_ra, ex_rf_waddr); end
    vectors++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %0h want 0", stall_if_id); end
    step;
    vectors++;
    if (ex_valid !== 1'b1 || ex_ra !== 3'd3 || ex_rf_waddr !== 3'd4 || ex_payload !== 36'hB00000002)
      begin errors++; $display("FAIL lu_add_in_ex: got v=%0h ra=%0h wa=%0h pl=%0h want v=1 ra=3 wa=4 pl=B00000002",
                               ex_valid, ex_ra, ex_rf_waddr, ex_payload); end
    $display("test_load_use done");
  endtask

  task automatic test_hazard_cases;
    logic [2:0] use_t [4] = '{3'b010, 3'b100, 3'b000, 3'b001};
    logic [2:0] ra_t  [4] = '{3'd0,   3'd5,   3'd5,   3'd4};
    logic [2:0] rb_t  [4] = '{3'd5,   3'd0,   3'd5,   3'd5};
    logic       exp_t [4] = '{1'b1,   1'b1,   1'b0,   1'b0};
    for (int i = 0; i < 4; i++) begin
      set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd5, 1, 36'h5);
      step;
      set_id(1, ra_t[i], rb_t[i], use_t[i], 1, 3'd6, 0, 36'h6);
      #1;
      vectors++;
      if (stall_if_id !== exp_t[i])
        begin errors++; $display("FAIL hazard_case%0d: got %0h want %0h", i, stall_if_id, exp_t[i]); end
      step;
    end
    $display("test_hazard_cases done");
  endtask

  task automatic test_r0_load;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd0, 1, 36'h7);
    step;
    set_id(1, 3'd0, 3'd0, 3'b011, 1, 3'd4, 0, 36'hC0FFEE);
    #1;
    vectors++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL r0_stall: got %0h want 0", stall_if_id); end
    step;
    vectors++;
    if (ex_valid !== 1'b1 || ex_payload !== 36'hC0FFEE)
      begin errors++; $display("FAIL r0_no_bubble: got v=%0h pl=%0h want v=1 pl=C0FFEE", ex_valid, ex_payload); end
    $display("test_r0_load done");
  endtask

  task automatic test_flush_lu;
    logic [15:0] cnt0;
    cnt0 = 16'd0;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd3, 1, 36'h11);
    step;
    set_id(1, 3'd3, 3'd0, 3'b001, 1, 3'd4, 0, 36'h22);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", stall_if_id); end
`ifdef HAZARD_PERF_CNT_EN
    cnt0 = stall_cnt;
`endif
    step;
    flush = 1'b0;
    vectors++;
    if (ex_valid !== 1'b0 || ex_is_load !== 1'b0 || ex_payload !== 36'd0)
      begin errors++; $display("FAIL flush_bubble: got v=%0h ld=%0h pl=%0h want all 0", ex_valid, ex_is_load, ex_payload); end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== cnt0) begin errors++; $display("FAIL flush_cnt: got %0h want %0h", stall_cnt, cnt0); end
`endif
    $display("test_flush_lu done (cnt0=%0h)", cnt0);
  endtask

  task automatic test_mem_stall;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd3, 1, 36'hCCC);
    step;
    set_id(1, 3'd2, 3'd0, 3'b001, 1, 3'd6, 0, 36'hDDD);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (stall_if_id !== 1'b1) begin errors++; $display("FAIL mstall_stall%0d: got %0h want 1", i, stall_if_id); end
      step;
      vectors++;
      if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_rf_waddr !== 3'd3 || ex_payload !== 36'hCCC)
        begin errors++; $display("FAIL mstall_hold%0d: got v=%0h ld=%0h wa=%0h pl=%0h want v=1 ld=1 wa=3 pl=CCC",
                                 i, ex_valid, ex_is_load, ex_rf_waddr, ex_payload); end
    end
    mem_stall = 1'b0;
    step;
    vectors++;
    if (ex_payload !== 36'hDDD) begin errors++; $display("FAIL mstall_release: got %0h want DDD", ex_payload); end
    $display("test_mem_stall done");
  endtask

  task automatic test_reset_mid_stall;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd3, 1, 36'h33);
    step;
    set_id(1, 3'd3, 3'd2, 3'b011, 1, 3'd4, 0, 36'h44);
    #1;
    vectors++;
    if (stall_if_id !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0h want 1", stall_if_id); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ex_valid !== 1'b0 || ex_is_load !== 1'b0 || stall_if_id !== 1'b0)
      begin errors++; $display("FAIL rst_async: got v=%0h ld=%0h stall=%0h want all 0", ex_valid, ex_is_load, stall_if_id); end
`ifdef HAZARD_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0h want 0", stall_cnt); end
`endif
    #1 rst_n = 1'b1;
    step;
    vectors++;
    if (ex_valid !== 1'b1 || ex_ra !== 3'd3 || ex_payload !== 36'h44)
      begin errors++; $display("FAIL rst_post_edge: got v=%0h ra=%0h pl=%0h want v=1 ra=3 pl=44", ex_valid, ex_ra, ex_payload); end
    $display("test_reset_mid_stall done");
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt;
    logic [15:0] c0;
    c0 = stall_cnt;
    set_id(1, 3'd1, 3'd0, 3'b001, 1, 3'd1, 1, 36'h55);
    step;
    step;
    vectors++;
    if (stall_cnt !== c0 + 16'd1) begin errors++; $display("FAIL cnt_incr: got %0h want %0h", stall_cnt, c0 + 16'd1); end
    force dut.stall_cnt_reg = 16'hFFFE;
    #1 release dut.stall_cnt_reg;
    for (int i = 0; i < 6; i++) step;
    vectors++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %0h want FFFF", stall_cnt); end
    $display("test_perf_cnt done");
  endtask
`endif

  initial begin
    test_reset;
    test_advance;
    test_load_use;
    test_hazard_cases;
    test_r0_load;
    test_flush_lu;
    test_mem_stall;
    test_reset_mid_stall;
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
